fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer_if.sv | 39 +++
 rtl/fetch_sequencer.sv | 151 +++++++++++++++
 tb/tb_fetch_sequencer.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_sequencer_if
//  Description : Redirect/stall bundle between the execute stage, the
//                instruction memory, the I-side flush logic and the fetch
//                sequencer. Signal suffixes are relative to the sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
interface fetch_sequencer_if;
  logic        br_valid_i;
  logic [31:0] br_target_i;
  logic        fencei_valid_i;
  logic [31:0] fencei_pc_i;
  logic        imem_busy_i;
  logic        flush_done_i;
  logic        pc_branch_o;
  logic [31:0] pc_target_o;
  logic        pc_hold_o;
  logic        flush_req_o;
  logic        fetch_valid_o;
  logic        err_o;

  // Sequencer side
  modport slave (
    input  br_valid_i, br_target_i, fencei_valid_i, fencei_pc_i,
    input  imem_busy_i, flush_done_i,
    output pc_branch_o, pc_target_o, pc_hold_o, flush_req_o,
    output fetch_valid_o, err_o
  );

  // Environment side (execute / memory / flush logic)
  modport master (
    output br_valid_i, br_target_i, fencei_valid_i, fencei_pc_i,
    output imem_busy_i, flush_done_i,
    input  pc_branch_o, pc_target_o, pc_hold_o, flush_req_o,
    input  fetch_valid_o, err_o
  );
endinterface
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_sequencer
//  Description : Steers the program counter: boot redirect, zero-latency
//                branch redirect, stalling on a busy instruction memory with
//                a newest-wins pending target, and FENCE.I flush handling
//                with a bounded wait and a sticky timeout flag.
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_sequencer #(
  parameter logic [31:0] RESET_VAL     = 32'h0000_0000,
  parameter int          FLUSH_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  fetch_sequencer_if.slave  bus
);

  // Counter only needs to reach FLUSH_TIMEOUT-1
  localparam int               CNT_W      = (FLUSH_TIMEOUT > 1) ? $clog2(FLUSH_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(FLUSH_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    ST_BOOT   = 3'd0,
    ST_RUN    = 3'd1,
    ST_HOLD   = 3'd2,
    ST_FLUSH  = 3'd3,
    ST_RESUME = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      pend_q,  pend_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             err_q,   err_d;

  logic        pc_branch;
  logic [31:0] pc_target;
  logic        pc_hold;
  logic        fetch_valid;

  // Next-state and PC-steering outputs; branch/target are combinational so a
  // redirect reaches the PC in the same cycle it is requested.
  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    pc_branch   = 1'b0;
    pc_target   = 32'h0;
    pc_hold     = 1'b0;
    fetch_valid = 1'b0;

    case (state_q)
      ST_BOOT: begin
        pc_branch = 1'b1;
        pc_target = RESET_VAL;
        state_d   = ST_RUN;
      end

      ST_RUN: begin
        if (bus.br_valid_i) begin
          // A branch always wins; a FENCE.I in the same cycle is dropped
          if (bus.imem_busy_i) begin
            pend_d  = bus.br_target_i;
            pc_hold = 1'b1;
            state_d = ST_HOLD;
          end else begin
            pc_branch = 1'b1;
            pc_target = bus.br_target_i;
          end
        end else if (bus.fencei_valid_i) begin
          // Retiring FENCE.I must not be lost to a memory stall
          pend_d  = bus.fencei_pc_i + 32'd4;
          cnt_d   = '0;
          pc_hold = 1'b1;
          state_d = ST_FLUSH;
        end else if (bus.imem_busy_i) begin
          pc_hold = 1'b1;
        end else begin
          fetch_valid = 1'b1;
        end
      end

      ST_HOLD: begin
        if (bus.imem_busy_i) begin
          pc_hold = 1'b1;
          if (bus.br_valid_i) begin
            pend_d = bus.br_target_i;
          end
        end else begin
          pc_branch = 1'b1;
          pc_target = bus.br_valid_i ? bus.br_target_i : pend_q;
          state_d   = ST_RUN;
        end
      end

      ST_FLUSH: begin
        pc_hold = 1'b1;
        cnt_d   = cnt_q + C_CNT_ONE;
        if (bus.flush_done_i) begin
          state_d = ST_RESUME;
        end else if (cnt_q == C_CNT_LAST) begin
          err_d   = 1'b1;
          state_d = ST_RESUME;
        end
      end

      ST_RESUME: begin
        if (bus.imem_busy_i) begin
          pc_hold = 1'b1;
        end else begin
          pc_branch = 1'b1;
          pc_target = pend_q;
          state_d   = ST_RUN;
        end
      end

      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  // State, pending target, flush counter and sticky error; reset abandons
  // any pending redirect or flush immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_BOOT;
      pend_q  <= 32'h0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Flush request is a decode of the registered state, so it drops the cycle
  // after the exit decision and clears asynchronously with reset.
  assign bus.flush_req_o   = (state_q == ST_FLUSH);
  assign bus.pc_branch_o   = pc_branch;
  assign bus.pc_target_o   = pc_target;
  assign bus.pc_hold_o     = pc_hold;
  assign bus.fetch_valid_o = fetch_valid;
  assign bus.err_o         = err_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_sequencer
//  Description : Self-checking bench for fetch_sequencer with directed
//                scenarios and randomized traffic against a flag-based
//                behavioural reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_sequencer;

  localparam logic [31:0] RV = 32'h0000_1000;
  localparam int          FT = 16;

  logic clk = 1'b0;
  logic rst_n;

  fetch_sequencer_if bus();

  fetch_sequencer #(.RESET_VAL(RV), .FLUSH_TIMEOUT(FT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Packed view of all outputs: branch, target, hold, flush_req, fetch_valid, err
  logic [36:0] obs;
  logic [36:0] exp_v;
  assign obs = {bus.pc_branch_o, bus.pc_target_o, bus.pc_hold_o,
                bus.flush_req_o, bus.fetch_valid_o, bus.err_o};

  // ---------------- reference model ----------------
  bit          m_boot;        // first cycle out of reset
  bit          m_waiting;     // a redirect to m_pend is owed once memory is free
  bit          m_may_replace; // a newer branch may replace the owed redirect
  bit          m_flushing;
  int          m_age;         // cycles already spent flushing
  bit          m_err;
  logic [31:0] m_pend;

  function automatic void model_reset();
    m_boot = 1; m_waiting = 0; m_may_replace = 0;
    m_flushing = 0; m_age = 0; m_err = 0; m_pend = 32'h0;
  endfunction

  function automatic logic [36:0] model_expect();
    logic br = 0, hold = 0, fl = 0, fv = 0;
    logic [31:0] tgt = 32'h0;
    if (m_boot) begin
      br = 1; tgt = RV;
    end else if (m_flushing) begin
      fl = 1; hold = 1;
    end else if (m_waiting) begin
      if (bus.imem_busy_i) hold = 1;
      else begin
        br  = 1;
        tgt = (m_may_replace && bus.br_valid_i) ? bus.br_target_i : m_pend;
      end
    end else if (bus.br_valid_i) begin
      if (bus.imem_busy_i) hold = 1;
      else begin br = 1; tgt = bus.br_target_i; end
    end else if (bus.fencei_valid_i || bus.imem_busy_i) begin
      hold = 1;
    end else begin
      fv = 1;
    end
    return {br, tgt, hold, fl, fv, m_err};
  endfunction

  function automatic void model_update();
    if (m_boot) begin
      m_boot = 0;
    end else if (m_flushing) begin
      if (bus.flush_done_i || m_age == FT - 1) begin
        m_flushing = 0; m_waiting = 1; m_may_replace = 0;
        if (!bus.flush_done_i) m_err = 1;
      end else begin
        m_age++;
      end
    end else if (m_waiting) begin
      if (bus.imem_busy_i) begin
        if (m_may_replace && bus.br_valid_i) m_pend = bus.br_target_i;
      end else begin
        m_waiting = 0;
      end
    end else if (bus.br_valid_i) begin
      if (bus.imem_busy_i) begin
        m_pend = bus.br_target_i; m_waiting = 1; m_may_replace = 1;
      end
    end else if (bus.fencei_valid_i) begin
      m_pend = bus.fencei_pc_i + 32'd4; m_flushing = 1; m_age = 0;
    end
  endfunction

  // ---------------- stimulus plumbing ----------------
  task automatic drive(input logic br, input logic [31:0] bt, input logic fe,
                       input logic [31:0] fpc, input logic busy, input logic done);
    bus.br_valid_i     = br;
    bus.br_target_i    = bt;
    bus.fencei_valid_i = fe;
    bus.fencei_pc_i    = fpc;
    bus.imem_busy_i    = busy;
    bus.flush_done_i   = done;
  endtask

  task automatic settle();
    #1;
    exp_v = model_expect();
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(negedge clk);
    settle();
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++; $display("FAIL reset_state: got %h want %h", obs, exp_v);
    end
    rst_n = 1'b1;
    settle();
    n_checks++;
    if (bus.pc_branch_o !== 1'b1 || bus.pc_target_o !== RV || bus.fetch_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL boot_redirect: got %h want br=1 tgt=%h", obs, RV);
    end
    advance();
    for (int i = 0; i < 4; i++) begin
      settle();
      n_checks++;
      if (obs !== exp_v || bus.fetch_valid_o !== 1'b1) begin
        n_fail++; $display("FAIL run_idle c%0d: got %h want %h", i, obs, exp_v);
      end
      advance();
    end
  endtask

  task automatic test_branch();
    drive(1, 32'h100, 0, 0, 0, 0);
    settle();
    n_checks++;
    if (obs !== exp_v || bus.pc_branch_o !== 1'b1 || bus.pc_target_o !== 32'h100) begin
      n_fail++; $display("FAIL branch_now: got %h want %h", obs, exp_v);
    end
    advance();
    drive(1, 32'h180, 1, 32'h40, 0, 0);
    settle();
    n_checks++;
    if (obs !== exp_v || bus.pc_target_o !== 32'h180 || bus.pc_hold_o !== 1'b0) begin
      n_fail++; $display("FAIL branch_over_fencei: got %h want %h", obs, exp_v);
    end
    advance();
    drive(0, 0, 0, 0, 0, 0);
    settle();
    n_checks++;
    if (obs !== exp_v || bus.flush_req_o !== 1'b0) begin
      n_fail++; $display("FAIL fencei_dropped: got %h want %h", obs, exp_v);
    end
    advance();
  endtask

  task automatic test_hold();
    logic        br_s   [4] = '{1, 1, 0, 0};
    logic [31:0] tgt_s  [4] = '{32'h200, 32'h300, 32'h0, 32'h0};
    logic        busy_s [4] = '{1, 1, 1, 0};
    int holds = 0;
    for (int i = 0; i < 4; i++) begin
      drive(br_s[i], tgt_s[i], 0, 0, busy_s[i], 0);
      settle();
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++; $display("FAIL hold c%0d: got %h want %h", i, obs, exp_v);
      end
      if (bus.pc_hold_o) holds++;
      if (i == 3) begin
        n_checks++;
        if (bus.pc_branch_o !== 1'b1 || bus.pc_target_o !== 32'h300 || holds != 3) begin
          n_fail++; $display("FAIL hold_release: got tgt %h holds %0d want 300 holds 3",
                             bus.pc_target_o, holds);
        end
      end
      advance();
    end
  endtask

  task automatic test_fencei();
    int nfl = 0;
    drive(0, 0, 1, 32'h40, 0, 0);
    settle();
    n_checks++;
    if (obs !== exp_v || bus.pc_hold_o !== 1'b1) begin
      n_fail++; $display("FAIL fencei_issue: got %h want %h", obs, exp_v);
    end
    advance();
    for (int k = 1; k <= 5; k++) begin
      drive(1, 32'hDEAD_0000, 1, 32'h99, 0, k == 5);
      settle();
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++; $display("FAIL flush c%0d: got %h want %h", k, obs, exp_v);
      end
      if (bus.flush_req_o) nfl++;
      advance();
    end
    drive(0, 0, 0, 0, 0, 0);
    settle();
    n_checks++;
    if (obs !== exp_v || bus.pc_target_o !== 32'h44 || bus.pc_branch_o !== 1'b1
        || bus.err_o !== 1'b0 || bus.flush_req_o !== 1'b0 || nfl != 5) begin
      n_fail++; $display("FAIL fencei_resume: got %h flushes %0d want tgt 44 flushes 5", obs, nfl);
    end
    advance();
  endtask

  task automatic test_timeout();
    int nfl = 0;
    bit seen = 0;
    drive(0, 0, 1, 32'h80, 0, 0);
    settle();
    advance();
    for (int k = 0; k < 3 * FT && !seen; k++) begin
      drive(0, 0, 0, 0, 0, 0);
      settle();
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++; $display("FAIL timeout c%0d: got %h want %h", k, obs, exp_v);
      end
      if (bus.flush_req_o) nfl++;
      else begin
        seen = 1;
        n_checks++;
        if (bus.pc_branch_o !== 1'b1 || bus.pc_target_o !== 32'h84 || bus.err_o !== 1'b1 || nfl != FT) begin
          n_fail++; $display("FAIL timeout_exit: got %h flushes %0d want tgt 84 err 1 flushes %0d",
                             obs, nfl, FT);
        end
      end
      advance();
    end
    n_checks++;
    if (!seen) begin
      n_fail++; $display("FAIL timeout_bound: flush_req still %b after %0d cycles want 0",
                         bus.flush_req_o, 3 * FT);
    end
    repeat (3) advance();
    settle();
    n_checks++;
    if (bus.err_o !== 1'b1) begin
      n_fail++; $display("FAIL err_sticky: got %b want 1", bus.err_o);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 6) == 0, $urandom & 32'hFFFF_FFFC, ($urandom % 10) == 0,
            $urandom & 32'hFFFF_FFFC, ($urandom % 3) == 0, ($urandom % 8) == 0);
      settle();
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++; $display("FAIL random c%0d: got %h want %h", i, obs, exp_v);
      end
      n_checks++;
      if (bus.pc_branch_o && bus.pc_hold_o) begin
        n_fail++; $display("FAIL branch_hold_excl c%0d: got both 1 want not both", i);
      end
      advance();
    end
  endtask

  task automatic test_wrap_reset();
    // Drain any owed redirect from the random phase
    for (int i = 0; i < FT + 4; i++) begin
      drive(0, 0, 0, 0, 0, 1);
      settle();
      advance();
    end
    drive(0, 0, 1, 32'hFFFF_FFFC, 0, 0);
    settle();
    advance();
    for (int k = 1; k <= 2; k++) begin
      drive(0, 0, 0, 0, 0, k == 2);
      settle();
      advance();
    end
    drive(0, 0, 0, 0, 0, 0);
    settle();
    n_checks++;
    if (obs !== exp_v || bus.pc_branch_o !== 1'b1 || bus.pc_target_o !== 32'h0) begin
      n_fail++; $display("FAIL wrap_target: got %h want %h", obs, exp_v);
    end
    advance();
    drive(0, 0, 1, 32'h10, 0, 0);
    settle();
    advance();
    drive(0, 0, 0, 0, 0, 0);
    settle();
    advance();
    settle();
    n_checks++;
    if (bus.flush_req_o !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset_flush: got %b want 1", bus.flush_req_o);
    end
    #2 rst_n = 1'b0;
    model_reset();
    settle();
    n_checks++;
    if (obs !== exp_v || bus.flush_req_o !== 1'b0 || bus.err_o !== 1'b0) begin
      n_fail++; $display("FAIL async_reset: got %h want %h", obs, exp_v);
    end
    @(negedge clk);
    rst_n = 1'b1;
    settle();
    n_checks++;
    if (obs !== exp_v || bus.pc_target_o !== RV) begin
      n_fail++; $display("FAIL reboot: got %h want %h", obs, exp_v);
    end
    advance();
    settle();
    n_checks++;
    if (obs !== exp_v || bus.fetch_valid_o !== 1'b1) begin
      n_fail++; $display("FAIL reboot_run: got %h want %h", obs, exp_v);
    end
    advance();
  endtask

  initial begin
    test_reset();
    test_branch();
    test_hold();
    test_fencei();
    test_timeout();
    test_random();
    test_wrap_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t want finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
